// File: rtl/serial_pattern_gen.sv
// Serial pattern generator: latches a switch pattern on a start edge and shifts it
// out MSB-first, holding each bit for DIV clock cycles, to drive the sequence detector.
module serial_pattern_gen #(
    parameter int WIDTH = 16,
    parameter int DIV   = 50000000,
    parameter int CNT_W = 26
) (
    input  logic             CLOCK_50,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic [5:0]       len,
    output logic             x,
    output logic             bit_valid,
    output logic [5:0]       bit_idx,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    localparam logic [5:0]       WIDTH_L  = 6'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    state_t             state_q, state_d;
    logic               startPrev_q;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [5:0]         len_q, len_d;
    logic [5:0]         idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;

    logic               startEdge;
    logic [5:0]         lenClamp;
    logic [WIDTH-1:0]   aligned;
    logic [5:0]         idxNext;

    assign startEdge = start & ~startPrev_q;
    assign lenClamp  = (len > WIDTH_L) ? WIDTH_L : len;
    // Left-align the pattern so the first bit to send always sits in the MSB.
    assign aligned   = data_in << (WIDTH_L - lenClamp);
    assign idxNext   = idx_q + 6'd1;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        len_d   = len_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (startEdge) begin
                    idx_d   = 6'd0;
                    cnt_d   = '0;
                    len_d   = lenClamp;
                    shift_d = aligned;
                    if (lenClamp == 6'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = SHIFT;
                        valid_d = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    idx_d = idxNext;
                    if (idxNext < len_q) begin
                        shift_d = {shift_q[WIDTH-2:0], 1'b0};
                        valid_d = 1'b1;
                    end else begin
                        // Clearing the shift register is what forces x back to 0 in IDLE.
                        shift_d = '0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                shift_d = '0;
            end
        endcase
    end

    // The start history resets high so a start held through reset release is not an edge.
    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            startPrev_q <= 1'b1;
            shift_q     <= '0;
            len_q       <= 6'd0;
            idx_q       <= 6'd0;
            cnt_q       <= '0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            startPrev_q <= start;
            shift_q     <= shift_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
        end
    end

    assign x         = shift_q[WIDTH-1];
    assign bit_valid = valid_q;
    assign bit_idx   = idx_q;
    assign busy      = (state_q == SHIFT);
    assign done      = done_q;

endmodule

// File: doc/serial_pattern_gen.md
Name: serial_pattern_gen

Overview:
- Upstream stimulus stage for the serial sequence detector. It produces that detector's serial input `x`.
- On a start request it latches a parallel pattern and a length from board switches. It then shifts the pattern out MSB-first, holding each bit for a programmable number of CLOCK_50 cycles.
- It provides busy/done status so the pattern can be observed on LEDs and detector output checked against a known bit stream.

Parameters:
- WIDTH, 16, maximum pattern length in bits (2..32).
- DIV, 50000000, CLOCK_50 cycles each bit is held (>=1); 1 s per bit at default.
- CNT_W, 26, width of bit-period counter; must satisfy 2^CNT_W >= DIV.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  start request, level input; a rising edge triggers a transfer.
- data_in  in  WIDTH  pattern; bit data_in[len-1] is sent first.
- len  in  6  number of bits to send; values above WIDTH are clamped to WIDTH.
- x  out  1  serial bit stream to the detector.
- bit_valid  out  1  one-cycle strobe on the first cycle of each new bit.
- bit_idx  out  6  count of bits already completed in the current transfer.
- busy  out  1  high while a transfer is in progress.
- done  out  1  one-cycle pulse when a transfer completes.

Behaviour:
- Reset: asynchronous on rst=0.
  - x=0, bit_valid=0, bit_idx=0, busy=0, done=0, state=IDLE, counters=0.
  - Start-edge history register resets to 1, so a start held high through reset release does not trigger.
  - Reset asserted mid-transfer aborts it immediately; done is not pulsed.
- Start detection:
  - start_d registers start every cycle.
  - edge = start & ~start_d.
  - An edge is accepted only when busy=0, including the cycle done is high; otherwise it is ignored.
- States:
  - IDLE:
    - x=0, busy=0.
    - On an accepted edge at clock edge k, latch data_in into the shift register and L = min(len, WIDTH).
    - If L=0: stay in IDLE, done=1 for cycle k+1, no bit_valid, busy stays 0.
    - Else go to SHIFT: x=data_in[L-1], bit_valid=1, busy=1, period counter=0, bit_idx=0 (all visible after edge k).
  - SHIFT:
    - The period counter increments each cycle.
    - When counter = DIV-1 and bit_idx+1 < L: counter=0, bit_idx+1, x = next lower bit, bit_valid=1 for one cycle.
    - When counter = DIV-1 and bit_idx+1 = L: go to IDLE, x=0, busy=0, done=1 for one cycle, bit_idx=L.
- Timing rules:
  - Every bit is held exactly DIV cycles. For DIV=1, bit_valid stays high for L consecutive cycles.
  - busy is high for exactly L*DIV cycles. done rises in the cycle after the last bit period.
- Holding rules:
  - data_in and len changes during SHIFT have no effect; the latched copies are used.
  - bit_idx holds its final value in IDLE until the next accepted start, which clears it to 0.
- x is a registered output with no combinational path from inputs, so it is glitch-free for the downstream detector.

Test Plan (bench with DIV=4, WIDTH=16):
1. Reset and idle:
   - Stimulus: rst=0 for 3 cycles with start=1, then release with start still 1.
   - Required: x=0, busy=0, done=0, bit_valid=0 throughout; no transfer starts.
2. Basic 5-bit transfer:
   - Stimulus: data_in=16'h0012, len=5, start edge.
   - Required: x = 1,0,0,1,0, each held 4 cycles; 5 bit_valid pulses spaced 4 cycles apart; busy high for 20 cycles; done pulses once; bit_idx=5; x=0 afterwards.
3. Start while busy:
   - Stimulus: during test 2, toggle start 0→1 at bit 2, and change data_in to 16'hFFFF.
   - Required: stream is unchanged; exactly one done pulse.
4. Length boundaries:
   - Stimulus A: len=0 → required: done one cycle after the edge, busy stays 0, no bit_valid.
   - Stimulus B: len=40, data_in=16'h8001 → required: 16 bits sent, starting 1, then 14 zeros, then 1; busy high for 64 cycles.
5. Reset mid-transfer:
   - Stimulus: assert rst during bit 3 of test 2.
   - Required: x, busy and bit_valid go to 0 asynchronously, with no done pulse.
   - Then: after release, a new start edge restarts the transfer from the first bit.
6. Back-to-back:
   - Stimulus: start edge arriving in the same cycle done=1.
   - Required: the new transfer is accepted; busy is low for exactly one cycle between the two transfers.
